serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor computing DIFF = X - Y, LSB first, one bit per clock.
- Built on a single-bit full-subtractor cell plus a registered borrow. It is the inverse-direction counterpart of the team's Full_Adder datapath.
- Used where area matters more than latency.
- Start/busy/done handshake toward the controlling logic.

---
 rtl/sub_pkg.sv | 14 +
 rtl/full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  // Controller states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Operand width used when the parent does not override it.
  localparam int unsigned DEFAULT_WIDTH = 32'd8;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// Single-bit full-subtractor cell: DIFF = X - Y - BORROW_IN.
// This is the subtract-direction sibling of the Full_Adder cell.
module full_subtractor (
  input  logic X,
  input  logic Y,
  input  logic BORROW_IN,
  output logic DIFF,
  output logic BORROW_OUT
);

  logic x_xor_y_s;

  // Difference bit and borrow generation for one bit position.
  always_comb begin
    x_xor_y_s  = X ^ Y;
    DIFF       = x_xor_y_s ^ BORROW_IN;
    // A borrow comes out when Y beats X outright, or when the bits tie
    // and a borrow was already pending from the lower position.
    BORROW_OUT = (~X & Y) | (~x_xor_y_s & BORROW_IN);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, DIFF = X - Y, LSB first.
// One bit is processed per clock through a single full-subtractor cell;
// the result is published (DIFF/BORROW_OUT) only on the edge entering FIN.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW_OUT
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Controller state.
  state_e           state_q, state_d;

  // Datapath: operand shift registers, result shift register, borrow, count.
  logic [WIDTH-1:0] sx_q, sx_d;
  logic [WIDTH-1:0] sy_q, sy_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered outputs.
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Outputs of the single subtractor cell.
  logic             cell_diff_s;
  logic             cell_bout_s;

  full_subtractor u_cell (
    .X          (sx_q[0]),
    .Y          (sy_q[0]),
    .BORROW_IN  (borrow_q),
    .DIFF       (cell_diff_s),
    .BORROW_OUT (cell_bout_s)
  );

  // Next-state, datapath and output decode for the three-state controller.
  always_comb begin
    state_d  = state_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          // Capture operands now; later changes on X/Y are irrelevant.
          sx_d     = X;
          sy_d     = Y;
          res_d    = {WIDTH{1'b0}};
          borrow_d = 1'b0;
          cnt_d    = {CNT_W{1'b0}};
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end

      RUN: begin
        sx_d     = {1'b0, sx_q[WIDTH-1:1]};
        sy_d     = {1'b0, sy_q[WIDTH-1:1]};
        res_d    = {cell_diff_s, res_q[WIDTH-1:1]};
        borrow_d = cell_bout_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Last bit: publish the completed word and the final borrow so
          // they are already valid in the DONE cycle.
          diff_d  = {cell_diff_s, res_q[WIDTH-1:1]};
          bout_d  = cell_bout_s;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      FIN: begin
        // Single DONE cycle; START seen here is dropped, not queued.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      sx_q     <= {WIDTH{1'b0}};
      sy_q     <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign DIFF       = diff_q;
  assign BORROW_OUT = bout_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  logic       CLK;
  logic       RST;
  logic       START;
  logic [7:0] X;
  logic [7:0] Y;
  logic       BUSY;
  logic       DONE;
  logic [7:0] DIFF;
  logic       BORROW_OUT;

  int         tests;
  int         failed;
  logic [7:0] prev_diff;   // bench-side record of the last published DIFF
  logic       prev_bout;

  serial_subtractor #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .X          (X),
    .Y          (Y),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .DIFF       (DIFF),
    .BORROW_OUT (BORROW_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation with cycle-exact timing checks.
  // disturb: re-pulse START and change X/Y during RUN.
  task automatic run_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                        input logic [7:0] exp_d, input logic exp_b, input bit disturb);
    @(negedge CLK);
    X = xv; Y = yv; START = 1'b1;
    @(posedge CLK);              // accepting edge t
    @(negedge CLK);              // cycle t+1
    START = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check({tag, "_busydone_run"}, {30'd0, BUSY, DONE}, 32'h2);
      check({tag, "_diff_hold"}, {23'd0, BORROW_OUT, DIFF}, {23'd0, prev_bout, prev_diff});
      if (disturb && i == 3) begin
        START = 1'b1; X = 8'h10; Y = 8'h01;
      end else if (disturb && i == 4) begin
        START = 1'b0; X = 8'hFF; Y = 8'h00;
      end
      @(negedge CLK);
    end
    // cycle t+9: result valid
    check({tag, "_busydone_fin"}, {30'd0, BUSY, DONE}, 32'h1);
    check({tag, "_diff"}, {24'd0, DIFF}, {24'd0, exp_d});
    check({tag, "_borrow"}, {31'd0, BORROW_OUT}, {31'd0, exp_b});
    @(negedge CLK);              // cycle t+10: back in IDLE
    check({tag, "_idle"}, {30'd0, BUSY, DONE}, 32'h0);
    check({tag, "_diff_held"}, {24'd0, DIFF}, {24'd0, exp_d});
    prev_diff = exp_d;
    prev_bout = exp_b;
  endtask

  initial begin
    tests = 0; failed = 0;
    prev_diff = 8'h00; prev_bout = 1'b0;
    RST = 1'b1; START = 1'b0; X = 8'h00; Y = 8'h00;

    // Reset
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("rst_busy", {31'd0, BUSY}, 32'h0);
    check("rst_done", {31'd0, DONE}, 32'h0);
    check("rst_diff", {24'd0, DIFF}, 32'h0);
    check("rst_borrow", {31'd0, BORROW_OUT}, 32'h0);

    // Basic, underflow and edge values
    run_op("basic_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("uflow_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("uflow_80_FF", 8'h80, 8'hFF, 8'h81, 1'b1, 1'b0);
    run_op("edge_00_00",  8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("edge_FF_FF",  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("edge_00_01",  8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

    // START re-pulse and X/Y changes during RUN are ignored
    run_op("ignore_20_07", 8'h20, 8'h07, 8'h19, 1'b0, 1'b1);

    // Reset in the 4th RUN cycle aborts the operation
    @(negedge CLK);
    X = 8'h33; Y = 8'h11; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);              // RUN cycle 1
    START = 1'b0;
    repeat (3) @(negedge CLK);   // RUN cycle 4
    check("abort_busy_before", {31'd0, BUSY}, 32'h1);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_busy", {31'd0, BUSY}, 32'h0);
    check("abort_done", {31'd0, DONE}, 32'h0);
    check("abort_diff", {24'd0, DIFF}, 32'h0);
    check("abort_borrow", {31'd0, BORROW_OUT}, 32'h0);
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check("abort_no_done", {30'd0, BUSY, DONE}, 32'h0);
      check("abort_diff_zero", {24'd0, DIFF}, 32'h0);
    end
    prev_diff = 8'h00;
    prev_bout = 1'b0;

    run_op("after_abort_0A_04", 8'h0A, 8'h04, 8'h06, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_subtractor
